// File: rtl/control_law_sequencer.sv
// -----------------------------------------------------------------------------
// control_law_sequencer
//
// Sample scheduler for the combinational LandauControlLaw datapath.
//   * Generates the control-loop sample tick (one pulse every PERIOD clocks
//     while en is high).
//   * Accepts one Q16.16 (a1,a2) sample per tick over valid/ready and drives
//     the law inputs a1/a2/test from registers.
//   * Waits a fixed settle window, saturates the law output b and presents it
//     downstream over valid/ready.
//   * Flags ticks that arrive while a transaction is still in flight (sticky
//     overrun).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its data stable until that transfer.
// in_ready/out_valid are decoded from the state register, so they never
// depend combinationally on in_valid/out_ready.
//
// Ports
//   clk          in   1   clock, all logic on rising edge
//   rst          in   1   synchronous reset, active-high
//   en           in   1   enable tick generation
//   test_req     in   1   requested test mode, sampled at input accept
//   clr_overrun  in   1   clears sticky overrun
//   in_a1        in   32  signed Q16.16 sample a1
//   in_a2        in   32  signed Q16.16 sample a2
//   in_valid     in   1   sample valid
//   in_ready     out  1   sequencer accepting a sample
//   law_a1       out  32  registered a1 to control law
//   law_a2       out  32  registered a2 to control law
//   law_test     out  1   registered test to control law
//   law_b        in   32  signed Q16.16 control law output (combinational)
//   out_b        out  32  saturated command, Q16.16
//   out_valid    out  1   out_b valid
//   out_ready    in   1   downstream accepts out_b
//   sat_hit      out  1   out_b was clamped (valid with out_valid)
//   busy         out  1   FSM not in IDLE
//   overrun      out  1   sticky: tick arrived while busy
//   dbg_state    out  3   current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module control_law_sequencer #(
    parameter int unsigned       PERIOD  = 1000,
    parameter int unsigned       SETTLE  = 2,
    parameter logic signed [31:0] SAT_MAX = 32'sh7FFF0000,
    parameter logic signed [31:0] SAT_MIN = 32'sh80010000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        test_req,
    input  logic        clr_overrun,
    input  logic [31:0] in_a1,
    input  logic [31:0] in_a2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] law_a1,
    output logic [31:0] law_a2,
    output logic        law_test,
    input  logic [31:0] law_b,
    output logic [31:0] out_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sat_hit,
    output logic        busy,
    output logic        overrun,
    output logic [2:0]  dbg_state
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SET_W = $clog2(SETTLE + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [SET_W-1:0] SET_LOAD   = SET_W'(SETTLE - 1);
    localparam logic [SET_W-1:0] SET_ONE    = SET_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // S_LAUNCH is the first clock after accept: the new law inputs have just
    // been registered, so the settle window only starts counting afterwards.
    // This gives accept-to-out_valid latency of SETTLE+1 clocks.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_IN = 3'd1,
        S_LAUNCH  = 3'd2,
        S_SETTLE  = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [31:0]        r_law_a1;
    logic [31:0]        r_law_a2;
    logic               r_law_test;
    logic [31:0]        r_out_b;
    logic               r_sat_hit;
    logic               r_overrun;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    state_t             w_state_next;
    logic               w_tick;
    logic               w_accept;
    logic               w_capture;
    logic signed [31:0] w_law_b_s;
    logic               w_over_max;
    logic               w_under_min;
    logic [31:0]        w_clamped;

    // Tick is a single-clock pulse on the last count of the period; it is
    // gated by en so dropping en stops ticks immediately.
    assign w_tick    = en && (r_tick_cnt == CNT_LAST);
    assign w_accept  = (r_state == S_WAIT_IN) && in_valid;
    assign w_capture = (r_state == S_SETTLE) && (r_settle_cnt == '0);

    // Full 32-bit signed compare; the clamp substitutes the limit itself.
    assign w_law_b_s   = signed'(law_b);
    assign w_over_max  = (w_law_b_s > SAT_MAX);
    assign w_under_min = (w_law_b_s < SAT_MIN);

    always_comb begin
        w_clamped = law_b;
        if (w_over_max) begin
            w_clamped = SAT_MAX;
        end else if (w_under_min) begin
            w_clamped = SAT_MIN;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_next = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Tick counter: held at 0 while en is low, so the first tick after en
    // rises comes a full PERIOD later.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (!en) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == CNT_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Settle counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt <= '0;
        end else if (w_accept) begin
            r_settle_cnt <= SET_LOAD;
        end else if ((r_state == S_SETTLE) && (r_settle_cnt != '0)) begin
            r_settle_cnt <= r_settle_cnt - SET_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Law input registers: only change at accept, otherwise hold the last
    // transaction's values.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_law_a1   <= '0;
            r_law_a2   <= '0;
            r_law_test <= 1'b0;
        end else if (w_accept) begin
            r_law_a1   <= in_a1;
            r_law_a2   <= in_a2;
            r_law_test <= test_req;
        end
    end

    // -------------------------------------------------------------------------
    // Output capture: out_b/sat_hit only load at the end of the settle
    // window, so they are stable for the whole time out_valid waits on
    // out_ready.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_b   <= '0;
            r_sat_hit <= 1'b0;
        end else if (w_capture) begin
            r_out_b   <= w_clamped;
            r_sat_hit <= w_over_max || w_under_min;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overrun: a tick while busy is dropped and recorded. Set has
    // priority over a same-clock clear.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_tick && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = (r_state == S_WAIT_IN);
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_IDLE);
    assign law_a1    = r_law_a1;
    assign law_a2    = r_law_a2;
    assign law_test  = r_law_test;
    assign out_b     = r_out_b;
    assign sat_hit   = r_sat_hit;
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_control_law_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for control_law_sequencer (PERIOD=16, SETTLE=2).
// The control law is emulated by the bench: law_b is a combinational function
// of the DUT's law_a1/law_a2/law_test, or a forced constant.
// A reference model tracks the sequencer as a transaction timeline (tick
// times from the enable history, accept time, result due time) and a compare
// process checks every output on every falling edge.
// -----------------------------------------------------------------------------
module tb_control_law_sequencer;

  localparam int P = 16;
  localparam int S = 2;
  localparam logic signed [31:0] SMAX = 32'sh7FFF0000;
  localparam logic signed [31:0] SMIN = 32'sh80010000;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        rst;
  logic        en;
  logic        test_req;
  logic        clr_overrun;
  logic [31:0] in_a1;
  logic [31:0] in_a2;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] law_a1;
  logic [31:0] law_a2;
  logic        law_test;
  logic [31:0] law_b;
  logic [31:0] out_b;
  logic        out_valid;
  logic        out_ready;
  logic        sat_hit;
  logic        busy;
  logic        overrun;
  logic [2:0]  dbg_state;

  logic        force_en;
  logic [31:0] force_val;

  int total;
  int bad;
  int cyc;

  control_law_sequencer #(
    .PERIOD (P),
    .SETTLE (S),
    .SAT_MAX(SMAX),
    .SAT_MIN(SMIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .test_req   (test_req),
    .clr_overrun(clr_overrun),
    .in_a1      (in_a1),
    .in_a2      (in_a2),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .law_a1     (law_a1),
    .law_a2     (law_a2),
    .law_test   (law_test),
    .law_b      (law_b),
    .out_b      (out_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sat_hit    (sat_hit),
    .busy       (busy),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Emulated control law and reference arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] law_fn(input logic [31:0] a1, input logic [31:0] a2,
                                         input logic t);
    return t ? (a1 - a2) : (a1 + a2);
  endfunction

  function automatic logic [31:0] clamp_fn(input logic [31:0] v);
    if ($signed(v) > SMAX) return SMAX;
    if ($signed(v) < SMIN) return SMIN;
    return v;
  endfunction

  assign law_b = force_en ? force_val : law_fn(law_a1, law_a2, law_test);

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Comparison helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. m_mode: 0 idle, 1 waiting for a sample, 2 result pending
  // until cycle m_due, 3 result presented downstream.
  // ---------------------------------------------------------------------------
  int          m_k;
  int          m_mode;
  int          m_due;
  logic        m_tick;
  logic [31:0] m_a1;
  logic [31:0] m_a2;
  logic        m_test;
  logic [31:0] m_out_b;
  logic        m_sat;
  logic        m_ov;
  logic [31:0] m_lb;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_k = 0; m_mode = 0; m_due = 0;
      m_a1 = '0; m_a2 = '0; m_test = 1'b0;
      m_out_b = '0; m_sat = 1'b0; m_ov = 1'b0;
    end else begin
      // en has been high for m_k consecutive edges; tick on the last of each period
      m_tick = en && ((m_k % P) == P - 1);
      if (m_tick && m_mode != 0) m_ov = 1'b1;
      else if (clr_overrun) m_ov = 1'b0;
      case (m_mode)
        0: if (m_tick) m_mode = 1;
        1: if (in_valid) begin
             m_a1 = in_a1; m_a2 = in_a2; m_test = test_req;
             m_due = cyc + S + 1;
             m_mode = 2;
           end
        2: if (cyc == m_due) begin
             m_lb = force_en ? force_val : law_fn(m_a1, m_a2, m_test);
             m_out_b = clamp_fn(m_lb);
             m_sat = ($signed(m_lb) > SMAX) || ($signed(m_lb) < SMIN);
             m_mode = 3;
           end
        3: if (out_ready) m_mode = 0;
        default: m_mode = 0;
      endcase
      m_k = en ? m_k + 1 : 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: compare every output each cycle away from the active edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    chk("in_ready",  32'(in_ready),  32'(m_mode == 1));
    chk("busy",      32'(busy),      32'(m_mode != 0));
    chk("out_valid", 32'(out_valid), 32'(m_mode == 3));
    chk("overrun",   32'(overrun),   32'(m_ov));
    chk("law_a1",    law_a1,         m_a1);
    chk("law_a2",    law_a2,         m_a2);
    chk("law_test",  32'(law_test),  32'(m_test));
    chk("out_b",     out_b,          m_out_b);
    chk("sat_hit",   32'(sat_hit),   32'(m_sat));
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input logic [31:0] a1, input logic [31:0] a2, input logic t,
                      output int acc);
    in_a1 = a1; in_a2 = a2; test_req = t; in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 4 * P; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_out(input int acc, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - acc;
        break;
      end
    end
    if (lat < 0) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int   acc;
  int   lat;
  logic saw;
  logic rdy_seen;

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1; en = 1'b0; test_req = 1'b0; clr_overrun = 1'b0;
    in_a1 = '0; in_a2 = '0; in_valid = 1'b0; out_ready = 1'b0;
    force_en = 1'b0; force_val = '0;

    repeat (3) step();
    @(negedge clk);
    chk("rst_out_b", out_b, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_law_a1", law_a1, 32'h0);
    step();
    rst = 1'b0; en = 1'b1; out_ready = 1'b1;

    // basic transaction: first tick PERIOD clocks after en rises
    send(32'h00020000, 32'h00010000, 1'b0, acc);
    chk("t1_law_a1", law_a1, 32'h00020000);
    chk("t1_law_a2", law_a2, 32'h00010000);
    wait_out(acc, lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_out_b", out_b, 32'h00030000);
    chk("t1_sat", 32'(sat_hit), 32'd0);

    // test mode applies to this transaction only
    send(32'h00020000, 32'h00010000, 1'b1, acc);
    chk("t2_law_test", 32'(law_test), 32'd1);
    wait_out(acc, lat);
    chk("t2_out_b", out_b, 32'h00010000);

    // saturation at both rails
    force_en = 1'b1; force_val = 32'h7FFFFFFF;
    send(32'h1, 32'h2, 1'b0, acc);
    wait_out(acc, lat);
    chk("t3_hi_out_b", out_b, 32'h7FFF0000);
    chk("t3_hi_sat", 32'(sat_hit), 32'd1);
    force_val = 32'h80000000;
    send(32'h3, 32'h4, 1'b0, acc);
    wait_out(acc, lat);
    chk("t3_lo_out_b", out_b, 32'h80010000);
    chk("t3_lo_sat", 32'(sat_hit), 32'd1);
    force_val = 32'h7FFF0000;
    send(32'h5, 32'h6, 1'b0, acc);
    wait_out(acc, lat);
    chk("t3_edge_sat", 32'(sat_hit), 32'd0);
    force_en = 1'b0;

    // downstream back-pressure longer than a period
    step(); out_ready = 1'b0;
    send(32'hFFFF0000, 32'h00008000, 1'b0, acc);
    wait_out(acc, lat);
    repeat (20) @(negedge clk);
    saw = 1'b0;
    for (int i = 0; i < 2 * P && !saw; i++) begin
      @(negedge clk);
      saw = overrun;
    end
    chk("t4_overrun_set", 32'(saw), 32'd1);
    chk("t4_out_b_held", out_b, 32'hFFFF8000);
    step(); out_ready = 1'b1;
    step(); clr_overrun = 1'b1;
    step(); clr_overrun = 1'b0;
    @(negedge clk);
    chk("t4_overrun_clr", 32'(overrun), 32'd0);

    // producer stalls for two periods
    saw = 1'b0;
    for (int i = 0; i < 2 * P && !saw; i++) begin
      @(negedge clk);
      saw = in_ready;
    end
    chk("t5_ready_seen", 32'(saw), 32'd1);
    repeat (2 * P) @(negedge clk);
    chk("t5_ready_held", 32'(in_ready), 32'd1);
    chk("t5_overrun", 32'(overrun), 32'd1);
    send(32'h00040000, 32'h00000001, 1'b0, acc);
    wait_out(acc, lat);
    chk("t5_out_b", out_b, 32'h00040001);
    step(); clr_overrun = 1'b1;
    step(); clr_overrun = 1'b0;

    // reset mid-transaction, then en low keeps the sequencer idle
    send(32'h00070000, 32'h00010000, 1'b1, acc);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_law_a1", law_a1, 32'h0);
    chk("t6_law_test", 32'(law_test), 32'd0);
    saw = 1'b0;
    repeat (3 * P) begin
      @(negedge clk);
      saw = saw | in_ready;
    end
    chk("t6_no_ready", 32'(saw), 32'd0);

    // randomized traffic
    step();
    en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rdy_seen = in_ready;
      step();
      if (in_valid && rdy_seen) in_valid = 1'b0;
      if (!in_valid && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: in_a1 = 32'h7FFE0000 + $urandom_range(0, 32'h3FFFF);
          1: in_a1 = 32'h80000000 + $urandom_range(0, 32'h3FFFF);
          default: in_a1 = $urandom;
        endcase
        in_a2    = $urandom_range(0, 32'h3FFFF);
        test_req = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready   = ($urandom_range(0, 3) != 0);
      clr_overrun = ($urandom_range(0, 30) == 0);
      en          = ($urandom_range(0, 199) != 0);
    end
    out_ready = 1'b1; in_valid = 1'b0; clr_overrun = 1'b0;
    repeat (2 * P) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
